// File: rtl/sipo_feeder_if.sv
// Parallel operand word handshake between the word source and sipo_feeder.
interface sipo_feeder_if #(
   parameter int unsigned size = 16
) ();
   logic [size*8-1:0] in_data;
   logic              in_valid;
   logic              in_ready;

   modport master (output in_data, output in_valid, input in_ready);
   modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/sipo_feeder.sv
// Serialises parallel operand words LSB-first into LANES 1-bit SIPO chains,
// with a one-entry holding buffer so back-to-back words stream without bubbles.
module sipo_feeder #(
   parameter int unsigned size  = 16,
   parameter int unsigned width = 16,
   parameter int unsigned CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   sipo_feeder_if.slave              bus,
   output logic [size*8/width-1:0]   sr_en,
   output logic [size*8/width-1:0]   sr_data,
   output logic                      load_done,
   output logic                      busy,
   output logic [CNT_W-1:0]          word_cnt
);

   localparam int unsigned WORD_W = size * 8;
   localparam int unsigned LANES  = WORD_W / width;
   localparam int unsigned BIT_W  = (width > 1) ? $clog2(width) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(width - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t                        state;
   logic [WORD_W-1:0]             hold_data;
   logic                          hold_full;
   logic [LANES-1:0][width-1:0]   work;
   logic [LANES-1:0][width-1:0]   work_shr;
   logic [BIT_W-1:0]              bit_cnt;
   logic                          xfer;

   assign bus.in_ready = !hold_full && !rst;
   assign xfer         = bus.in_valid && bus.in_ready;
   assign busy         = (state == SHIFT) || hold_full;

   // Every lane drops its LSB onto the chain each shift cycle.
   always_comb begin
      for (int k = 0; k < int'(LANES); k++) begin
         work_shr[k] = work[k] >> 1;
      end
   end

   // Chain drive is purely a function of registered state.
   always_comb begin
      sr_en   = '0;
      sr_data = '0;
      if (state == SHIFT) begin
         sr_en = '1;
         for (int k = 0; k < int'(LANES); k++) begin
            sr_data[k] = work[k][0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_data <= '0;
         hold_full <= 1'b0;
         work      <= '0;
         bit_cnt   <= '0;
         load_done <= 1'b0;
         word_cnt  <= '0;
      end else begin
         load_done <= 1'b0;
         // A transfer only happens with the buffer empty, so it never races a reload.
         if (xfer) begin
            hold_data <= bus.in_data;
            hold_full <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (hold_full) begin
                  work      <= hold_data;
                  hold_full <= 1'b0;
                  bit_cnt   <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_cnt == LAST_BIT) begin
                  load_done <= 1'b1;
                  word_cnt  <= word_cnt + CNT_W'(1);
                  bit_cnt   <= '0;
                  if (hold_full) begin
                     work      <= hold_data;
                     hold_full <= 1'b0;
                  end else begin
                     work  <= work_shr;
                     state <= IDLE;
                  end
               end else begin
                  work    <= work_shr;
                  bit_cnt <= bit_cnt + BIT_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sipo_feeder.sv
// Bench for sipo_feeder: two configurations (width 16 / width 8 with a 2-bit
// counter) checked against a word-level scoreboard rebuilt from the serial lanes.
module tb_sipo_feeder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sipo_feeder_if #(.size(16)) ifa ();
   sipo_feeder_if #(.size(16)) ifb ();

   logic [7:0]  a_en, a_data;
   logic        a_ld, a_busy;
   logic [15:0] a_cnt;
   logic [15:0] b_en, b_data;
   logic        b_ld, b_busy;
   logic [1:0]  b_cnt;

   sipo_feeder #(.size(16), .width(16), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa),
      .sr_en(a_en), .sr_data(a_data), .load_done(a_ld), .busy(a_busy), .word_cnt(a_cnt)
   );

   sipo_feeder #(.size(16), .width(8), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb),
      .sr_en(b_en), .sr_data(b_data), .load_done(b_ld), .busy(b_busy), .word_cnt(b_cnt)
   );

   int checks = 0;
   int failures = 0;

   // Selected-DUT view
   int          sel;
   int          W, lanes, cmod;
   logic [15:0] mask;
   logic [15:0] s_en, s_data, s_cnt;
   logic        s_ld, s_busy;

   // Driver and scoreboard state
   logic [127:0] tx_q[$];
   logic [127:0] acc_q[$];
   int           ld_cyc[$];
   int           cnt_at_ld[$];
   int           gate_pct;
   int           en_cycles, run_len, maxrun, ldcount, xfer_n, cyc;
   bit           prev_done;
   int           low_cnt[8];
   logic [15:0]  lane_bits[16];
   logic [15:0]  last_lane[16];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sample_outputs();
      if (sel == 0) begin
         s_en = 16'(a_en); s_data = 16'(a_data); s_ld = a_ld; s_cnt = a_cnt; s_busy = a_busy;
      end else begin
         s_en = b_en; s_data = b_data; s_ld = b_ld; s_cnt = 16'(b_cnt); s_busy = b_busy;
      end
   endtask

   // Word-level reference: gather lane bits while enabled, rebuild the word after W shifts.
   task automatic model_update();
      logic [127:0] got;
      if (rst) begin
         acc_q.delete();
         en_cycles = 0; prev_done = 1'b0; ldcount = 0; run_len = 0;
         chk("rst_sr_en", s_en, 0);
         chk("rst_load_done", s_ld, 0);
         chk("rst_word_cnt", s_cnt, 0);
         chk("rst_busy", s_busy, 0);
      end else begin
         chk("load_done", s_ld, prev_done);
         if (prev_done) begin
            ldcount++;
            ld_cyc.push_back(cyc);
            cnt_at_ld.push_back(int'(s_cnt));
         end
         prev_done = 1'b0;
         chk("word_cnt", s_cnt, ldcount % cmod);
         if (s_en == mask) begin
            chk("busy_while_shift", s_busy, 1);
            for (int k = 0; k < lanes; k++) lane_bits[k][en_cycles] = s_data[k];
            en_cycles++;
            run_len++;
            if (run_len > maxrun) maxrun = run_len;
            if (en_cycles == W) begin
               got = '0;
               for (int k = 0; k < lanes; k++) begin
                  for (int j = 0; j < W; j++) got[k*W + j] = lane_bits[k][j];
                  last_lane[k] = lane_bits[k];
               end
               chk("word_expected", acc_q.size() > 0, 1);
               if (acc_q.size() > 0) chk("word_data", got, acc_q.pop_front());
               en_cycles = 0;
               prev_done = 1'b1;
            end
         end else begin
            chk("sr_en_idle", s_en, 0);
            chk("sr_data_idle", s_data, 0);
            run_len = 0;
         end
      end
   endtask

   // One clock: drive at negedge, decide transfer, sample at next negedge.
   task automatic cycle();
      logic         vld, rdy, xfer;
      logic [127:0] din;
      if (tx_q.size() > 0 && $urandom_range(99) < gate_pct) begin
         din = tx_q[0];
         vld = 1'b1;
      end else begin
         din = {$urandom(), $urandom(), $urandom(), $urandom()};
         vld = 1'b0;
      end
      ifa.in_data  = din;
      ifb.in_data  = din;
      ifa.in_valid = vld && (sel == 0);
      ifb.in_valid = vld && (sel == 1);
      #1;
      rdy = (sel == 0) ? ifa.in_ready : ifb.in_ready;
      if (rst) chk("ready_in_reset", rdy, 0);
      else if (!rdy && xfer_n < 8) low_cnt[xfer_n]++;
      xfer = vld && rdy;
      @(posedge clk);
      if (xfer) begin
         acc_q.push_back(tx_q.pop_front());
         xfer_n++;
      end
      @(negedge clk);
      cyc++;
      sample_outputs();
      model_update();
   endtask

   task automatic run_cycles(input int n);
      repeat (n) cycle();
   endtask

   task automatic check_drained(input string tag);
      chk({tag, "_tx_empty"}, tx_q.size(), 0);
      chk({tag, "_acc_empty"}, acc_q.size(), 0);
      chk({tag, "_busy_idle"}, s_busy, 0);
   endtask

   task automatic clear_stats();
      maxrun = 0; run_len = 0; xfer_n = 0;
      for (int i = 0; i < 8; i++) low_cnt[i] = 0;
      ld_cyc.delete();
      cnt_at_ld.delete();
   endtask

   task automatic do_reset(input int s);
      sel   = s;
      W     = (s == 0) ? 16 : 8;
      lanes = (s == 0) ? 8 : 16;
      mask  = (s == 0) ? 16'h00FF : 16'hFFFF;
      cmod  = (s == 0) ? 65536 : 4;
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      clear_stats();
   endtask

   initial begin
      logic [127:0] w;
      int exp6[5];
      exp6 = '{1, 2, 3, 0, 1};
      rst = 1'b1;
      gate_pct = 100;
      cyc = 0; en_cycles = 0; prev_done = 1'b0; ldcount = 0;
      ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
      ifa.in_data = '0; ifb.in_data = '0;
      sel = 0;

      // Single recognisable word, lane k = A5A0+k
      do_reset(0);
      for (int k = 0; k < 8; k++) w[k*16 +: 16] = 16'(16'hA5A0 + k);
      tx_q.push_back(w);
      run_cycles(24);
      chk("t1_enable_run", maxrun, 16);
      chk("t1_load_pulses", ld_cyc.size(), 1);
      chk("t1_word_cnt", a_cnt, 1);
      check_drained("t1");

      // Three streamed words with valid held high
      do_reset(0);
      repeat (3) tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      run_cycles(60);
      chk("t2_enable_run", maxrun, 48);
      chk("t2_backpressure_cycles", low_cnt[2], 15);
      chk("t2_load_pulses", ld_cyc.size(), 3);
      if (ld_cyc.size() == 3) begin
         chk("t2_ld_gap1", ld_cyc[1] - ld_cyc[0], 16);
         chk("t2_ld_gap2", ld_cyc[2] - ld_cyc[1], 16);
      end
      chk("t2_word_cnt", a_cnt, 3);
      check_drained("t2");

      // Randomly gated valid
      do_reset(0);
      gate_pct = 45;
      repeat (10) tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      run_cycles(400);
      gate_pct = 100;
      chk("t3_words_done", ldcount, 10);
      check_drained("t3");

      // Reset while shifting bit 7 with a second word held
      do_reset(0);
      repeat (2) tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      for (int i = 0; i < 40 && en_cycles < 8; i++) cycle();
      chk("t4_reached_bit7", en_cycles, 8);
      chk("t4_hold_full_before", a_busy, 1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      #1;
      chk("t4_ready_after_reset", ifa.in_ready, 1);
      run_cycles(20);
      chk("t4_no_load_done", ld_cyc.size(), 0);
      chk("t4_word_cnt", a_cnt, 0);
      tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      run_cycles(24);
      chk("t4_fresh_word", ld_cyc.size(), 1);
      check_drained("t4");

      // width 8: sixteen lanes
      do_reset(1);
      tx_q.push_back(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      run_cycles(14);
      chk("t5_enable_run", maxrun, 8);
      chk("t5_lane0", last_lane[0][7:0], 8'h10);
      chk("t5_lane15", last_lane[15][7:0], 8'h01);
      check_drained("t5");

      // 2-bit counter wrap over five streamed words
      do_reset(1);
      repeat (5) tx_q.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      run_cycles(52);
      chk("t6_enable_run", maxrun, 40);
      chk("t6_load_pulses", cnt_at_ld.size(), 5);
      for (int i = 0; i < 5 && i < cnt_at_ld.size(); i++) chk("t6_cnt_seq", cnt_at_ld[i], exp6[i]);
      check_drained("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
